// File: rtl/int_exec_unit_if.sv
// int_exec_unit_if: issue-side and CDB-side valid/ready bundle for int_exec_unit
interface int_exec_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_op;
    logic             in_alt;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_alu_op, in_alt, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_alu_op, in_alt, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/int_exec_unit.sv
// int_exec_unit: single-cycle ALU plus multi-cycle MULT with valid/ready on issue and CDB; optional flush port under INT_EXEC_FLUSH_EN
module int_exec_unit #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 6,
    parameter int MULT_LAT = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef INT_EXEC_FLUSH_EN
    input logic flush,
`endif
    int_exec_unit_if.slave io
);
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  prod;
    logic signed [XLEN-1:0] sra;
    logic [4:0]       sh;
    logic             kill;
    logic             accept;

`ifdef INT_EXEC_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign io.in_ready   = !kill && (state_q == IDLE || (state_q == DONE && io.out_ready));
    assign accept        = io.in_valid && io.in_ready;
    assign io.out_valid  = state_q == DONE;
    assign io.busy       = state_q == MULT;
    assign io.out_result = res_q;
    assign io.out_tag    = tag_q;
    assign prod          = a_q * b_q;
    assign sh            = io.in_b[4:0];
    // kept separate so the signed shift is not pulled into an unsigned context
    assign sra           = $signed(io.in_a) >>> sh;

    always_comb begin
        case (io.in_alu_op)
            4'd0:        alu_res = io.in_a + io.in_b;
            4'd1:        alu_res = io.in_a - io.in_b;
            4'd3, 4'd9:  alu_res = io.in_a << sh;
            4'd4:        alu_res = {{(XLEN-1){1'b0}}, io.in_alt ? io.in_a < io.in_b : $signed(io.in_a) < $signed(io.in_b)};
            4'd5:        alu_res = io.in_a ^ io.in_b;
            4'd6, 4'd10: alu_res = io.in_alt ? $unsigned(sra) : io.in_a >> sh;
            4'd7:        alu_res = io.in_a | io.in_b;
            4'd8:        alu_res = io.in_a & io.in_b;
            default:     alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        tag_d   = tag_q;
        a_d     = a_q;
        b_d     = b_q;
        if (state_q == DONE && io.out_ready) state_d = IDLE;
        if (state_q == MULT) begin
            state_d = cnt_q == 4'd0 ? DONE : MULT;
            res_d   = cnt_q == 4'd0 ? prod : res_q;
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end
        if (accept) begin
            tag_d = io.in_tag;
            if (io.in_alu_op == 4'd2) begin
                state_d = MULT;
                cnt_d   = 4'(MULT_LAT - 1);
                a_d     = io.in_a;
                b_d     = io.in_b;
            end else begin
                state_d = DONE;
                res_d   = alu_res;
            end
        end
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
endmodule

// File: tb/tb_int_exec_unit.sv
// tb_int_exec_unit: directed and random stimulus with a queued scoreboard against a behavioural model
module tb_int_exec_unit;
    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
`ifdef INT_EXEC_FLUSH_EN
    logic flush = 1'b0;
`endif
    int checks = 0;
    int failures = 0;
    logic rand_bp = 1'b0;
    exp_t sb[$];
    logic [31:0] edges[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};

    int_exec_unit_if #(.XLEN(32), .TAG_W(6)) io ();

    int_exec_unit #(.XLEN(32), .TAG_W(6), .MULT_LAT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef INT_EXEC_FLUSH_EN
        .flush(flush),
`endif
        .io(io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference semantics written from the opcode table, not from the datapath
    function automatic logic [31:0] model(input logic [3:0] op, input logic alt, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [4:0] s;
        s = b[4:0];
        p = {32'h0, a} * {32'h0, b};
        case (op)
            4'd0: return a + b;
            4'd1: return a + ~b + 32'd1;
            4'd2: return p[31:0];
            4'd3, 4'd9: return a << s;
            4'd4: return alt ? 32'(a < b) : 32'((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
            4'd5: return a ^ b;
            4'd6, 4'd10: return (a >> s) | ((alt && a[31]) ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd7: return a | b;
            4'd8: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic alt, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input logic [31:0] exp, output int waits);
        io.in_valid = 1'b1;
        io.in_alu_op = op;
        io.in_alt = alt;
        io.in_a = a;
        io.in_b = b;
        io.in_tag = tag;
        waits = 0;
        forever begin
            if (rand_bp) io.out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (io.in_ready) begin
                sb.push_back('{exp, tag});
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waits++;
            if (waits > 60) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout: in_ready never 1 for tag %0d", tag);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        io.in_valid = 1'b0;
        repeat (n) begin
            if (rand_bp) io.out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && io.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out: result %h tag %0d with nothing expected", io.out_result, io.out_tag);
                end else begin
                    chk("sb_result", io.out_result, sb[0].res);
                    chk("sb_tag", 32'(io.out_tag), 32'(sb[0].tag));
                    if (io.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] op;
        logic alt;
        logic [31:0] a, b;
        logic [5:0] tag;
        rst_n = 1'b0;
        io.in_valid = 1'b1;
        io.in_alu_op = 4'd0;
        io.in_alt = 1'b0;
        io.in_a = 32'd1;
        io.in_b = 32'd1;
        io.in_tag = 6'd1;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_hold_out_valid", 32'(io.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        io.in_valid = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(io.out_valid), 32'd0);
        chk("reset_out_result", io.out_result, 32'd0);
        chk("reset_out_tag", 32'(io.out_tag), 32'd0);
        chk("reset_busy", 32'(io.busy), 32'd0);
        chk("reset_in_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;

        issue(4'd0, 1'b0, 32'd5, 32'd7, 6'd3, 32'd12, w);
        chk("b2b_add_wait", w, 0);
        issue(4'd1, 1'b0, 32'd5, 32'd7, 6'd4, 32'hFFFF_FFFE, w);
        chk("b2b_sub_wait", w, 0);
        io.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_sub_valid", 32'(io.out_valid), 32'd1);
        chk("b2b_sub_tag", 32'(io.out_tag), 32'd4);
        chk("b2b_sub_result", io.out_result, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;

        issue(4'd2, 1'b0, 32'hFFFF_FFFF, 32'd3, 6'd9, 32'hFFFF_FFFD, w);
        io.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mult_busy", 32'(io.busy), 32'd1);
            chk("mult_in_ready", 32'(io.in_ready), 32'd0);
            chk("mult_out_valid_early", 32'(io.out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mult_out_valid", 32'(io.out_valid), 32'd1);
        chk("mult_result", io.out_result, 32'hFFFF_FFFD);
        chk("mult_tag", 32'(io.out_tag), 32'd9);
        @(posedge clk);
        #1;

        io.out_ready = 1'b0;
        issue(4'd5, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd5, 32'hFF00_FF00, w);
        io.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(io.out_valid), 32'd1);
            chk("bp_result", io.out_result, 32'hFF00_FF00);
            chk("bp_in_ready", 32'(io.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_released", 32'(io.out_valid), 32'd0);
        @(posedge clk);
        #1;

        issue(4'd6, 1'b1, 32'h8000_0000, 32'd4, 6'd10, 32'hF800_0000, w);
        issue(4'd6, 1'b0, 32'h8000_0000, 32'd4, 6'd11, 32'h0800_0000, w);
        issue(4'd10, 1'b1, 32'h8000_0000, 32'd36, 6'd12, 32'hF800_0000, w);
        issue(4'd9, 1'b0, 32'h0000_0003, 32'd31, 6'd13, 32'h8000_0000, w);
        issue(4'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 6'd14, 32'd1, w);
        issue(4'd4, 1'b1, 32'hFFFF_FFFF, 32'd1, 6'd15, 32'd0, w);
        issue(4'd12, 1'b0, 32'h1234_5678, 32'h1, 6'd16, 32'd0, w);
        idle(2);

        issue(4'd2, 1'b0, 32'd6, 32'd7, 6'd17, 32'd42, w);
        io.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_mult_busy", 32'(io.busy), 32'd0);
        chk("rst_mid_mult_valid", 32'(io.out_valid), 32'd0);
        chk("rst_mid_mult_result", io.out_result, 32'd0);
        chk("rst_mid_mult_in_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;

`ifdef INT_EXEC_FLUSH_EN
        issue(4'd2, 1'b0, 32'd9, 32'd9, 6'd20, 32'd81, w);
        io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        io.in_valid = 1'b1;
        io.in_alu_op = 4'd0;
        io.in_alt = 1'b0;
        io.in_a = 32'd2;
        io.in_b = 32'd3;
        io.in_tag = 6'd21;
        @(negedge clk);
        chk("flush_in_ready", 32'(io.in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("flush_out_valid", 32'(io.out_valid), 32'd0);
        chk("flush_busy", 32'(io.busy), 32'd0);
        chk("flush_next_accept", 32'(io.in_ready), 32'd1);
        if (io.in_ready) sb.push_back('{32'd5, 6'd21});
        @(posedge clk);
        #1;
        idle(6);
`endif

        rand_bp = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op = 4'($urandom_range(0, 15));
            alt = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 3)] : $urandom();
            b = $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 3)] : $urandom();
            tag = 6'($urandom_range(0, 63));
            issue(op, alt, a, b, tag, model(op, alt, a, b), w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        rand_bp = 1'b0;
        io.out_ready = 1'b1;
        io.in_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_exec_unit.md
Name: int_exec_unit

Overview:
- Integer execution unit that consumes the 4-bit ALU_op produced by ALU_control, together with issued operands and a ROB tag.
- Sits between the integer issue queue and the common data bus (CDB) writeback arbiter.
- Single-cycle ops complete with throughput 1. MULT is a multi-cycle op that occupies the unit.
- Valid/ready handshake on both the issue side and the CDB side; the result is held until accepted.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 6, ROB tag width
- MULT_LAT, 4, cycles from MULT accept to out_valid (legal range 2..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_alu_op  in  4  ALU_op encoding: 0 add, 1 sub, 2 mult, 3 sll, 4 slt, 5 xor, 6 sr, 7 or, 8 and, 9 slli, 10 sri
- in_alt  in  1  op4: 1=unsigned compare; op6/op10: 1=arithmetic shift; ignored otherwise
- in_a  in  XLEN  operand rs1
- in_b  in  XLEN  operand rs2 or sign-extended immediate
- in_tag  in  TAG_W  ROB tag
- out_valid  out  1  result available
- out_ready  in  1  CDB grant
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of out_result
- busy  out  1  high in MULT state

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset values: state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0, mult counter=0.
- FSM states: IDLE, MULT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when in_valid & in_ready.
- IDLE/DONE accept of a non-mult op: the result is registered. Next state is DONE with out_valid=1 on the following cycle (latency 1).
- IDLE/DONE accept of op 2:
  - latch operands and tag;
  - next state MULT, counter loaded with MULT_LAT-1;
  - out_valid=0 while in MULT.
- MULT: the counter decrements each cycle. When the counter reaches 0, out_result = low XLEN bits of in_a*in_b (signed and unsigned low halves are identical), and next state is DONE. The result appears exactly MULT_LAT cycles after accept.
- DONE: out_valid=1; out_result and out_tag are held stable while out_ready=0.
  - out_ready & no accept: next state IDLE.
  - out_ready & accept: back-to-back, as above.
- MULT ignores in_valid (in_ready=0); a pending request waits.
- Arithmetic, all results XLEN bits with wrap-around:
  - add/sub modulo 2^XLEN;
  - shifts use in_b[4:0] only;
  - sll and slli are identical;
  - op6/op10: in_alt=1 gives arithmetic right shift, 0 gives logical;
  - slt: result 1 or 0, zero-extended; signed compare, or unsigned if in_alt.
- Opcodes 11..15: result 0; the op is still accepted and completes in 1 cycle (no hang).
- Reset mid-MULT or mid-DONE: the in-flight result is discarded and all outputs return to reset values on the next edge.

Optional Feature:
- Macro INT_EXEC_FLUSH_EN.
- When defined: adds input port flush (1 bit). flush=1 forces next state IDLE, out_valid=0, and counter=0 on the next edge, taking priority over any accept or completion that cycle. in_ready=0 during a flush cycle.
- When undefined: no flush port; speculation recovery is handled upstream only.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_result=0, in_ready=1 after release.
- Back-to-back throughput, out_ready=1:
  - add 5+7 tag 3, then sub 5-7 tag 4 on consecutive cycles;
  - -> out_result 12 (tag 3), then 0xFFFFFFFE (tag 4) on consecutive cycles;
  - in_ready stays 1.
- MULT latency, MULT_LAT=4: 0xFFFFFFFF*3 tag 9 -> in_ready=0 and busy=1 for 4 cycles; out_valid on the 4th cycle after accept with 0xFFFFFFFD, tag 9.
- Backpressure: xor 0xF0F0F0F0^0x0FF00FF0 with out_ready=0 for 3 cycles -> out_result 0xFF00FF00 stable, in_ready=0; released one cycle after out_ready=1.
- Shifts and compares:
  - sr 0x80000000 by 4: in_alt=1 -> 0xF8000000; in_alt=0 -> 0x08000000;
  - slt -1 vs 1: signed -> 1; unsigned -> 0;
  - op 12 -> 0.
- Flush (INT_EXEC_FLUSH_EN): flush asserted 2 cycles into a MULT -> out_valid never rises for that tag; the next add is accepted the cycle after flush.
